// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and helpers for the PPU fetch sequencers.
//   fetch_state_e  : background tile fetch states, IDLE..PUSH (3 bits)
//   VRAM_AW        : VRAM byte-address width (0x0000 maps to CPU 0x8000)
//   tile_data_addr : tile-data byte address for one bitplane row
package ppu_pkg;

  localparam int VRAM_AW = 13;

  // Each VRAM access is an address phase (X0) followed by a data phase (X1).
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAP0 = 3'd1,
    MAP1 = 3'd2,
    LO0  = 3'd3,
    LO1  = 3'd4,
    HI0  = 3'd5,
    HI1  = 3'd6,
    PUSH = 3'd7
  } fetch_state_e;

  // 16 bytes per tile, 2 bytes per row, bitplane select in bit 0.
  // Bit 12 is set only for signed addressing with a non-negative index,
  // which folds the 0x1000-based signed window onto 0x0800..0x17FF.
  function automatic logic [12:0] tile_data_addr(input logic       sel,
                                                 input logic [7:0] idx,
                                                 input logic [2:0] fine_y,
                                                 input logic       hi);
    return {~(sel | idx[7]), idx, fine_y, hi};
  endfunction

endpackage

// File: rtl/bg_tile_fetcher_if.sv
// bg_tile_fetcher_if: VRAM read port plus BG pixel FIFO load port.
//   vram_addr  : VRAM read address           (fetcher -> VRAM)
//   vram_rd    : VRAM read strobe            (fetcher -> VRAM)
//   vram_data  : read data, valid in X1      (VRAM -> fetcher)
//   push       : load pix_lo/pix_hi now      (fetcher -> FIFO)
//   pix_lo     : low bitplane byte           (fetcher -> FIFO)
//   pix_hi     : high bitplane byte          (fetcher -> FIFO)
//   fifo_empty : FIFO can accept 8 pixels    (FIFO -> fetcher)
// Modports: master = fetcher side, slave = VRAM/FIFO side.
interface bg_tile_fetcher_if #(
  parameter int AW = 13
);
  logic [AW-1:0] vram_addr;
  logic          vram_rd;
  logic [7:0]    vram_data;
  logic          push;
  logic [7:0]    pix_lo;
  logic [7:0]    pix_hi;
  logic          fifo_empty;

  modport master (
    output vram_addr, vram_rd, push, pix_lo, pix_hi,
    input  vram_data, fifo_empty
  );

  modport slave (
    input  vram_addr, vram_rd, push, pix_lo, pix_hi,
    output vram_data, fifo_empty
  );
endinterface

// File: rtl/bg_tile_addr.sv
// bg_tile_addr: combinational tile-data address generator, shared by the
// background and sprite fetchers.
//   sel    in  1  1 = unsigned 0x0000 base, 0 = signed 0x1000 base
//   idx    in  8  tile index
//   fine_y in  3  row within tile
//   hi     in  1  0 = low bitplane, 1 = high bitplane
//   addr   out 13 VRAM byte address
module bg_tile_addr (
  input  logic        sel,
  input  logic [7:0]  idx,
  input  logic [2:0]  fine_y,
  input  logic        hi,
  output logic [12:0] addr
);
  import ppu_pkg::*;

  assign addr = tile_data_addr(sel, idx, fine_y, hi);
endmodule

// File: rtl/bg_tile_fetcher.sv
// bg_tile_fetcher: background/window tile fetch sequencer.
// Reads the tile index at map_addr, fetches the low then high bitplane
// byte of row fine_y, then loads the 8-pixel row into the BG FIFO and
// pulses map_step so the upstream map-X counter advances.
//
// Ports:
//   clk2         in   video clock, rising-edge
//   reset_video2 in   asynchronous reset, active-high
//   fetch_start  in   line start / window trigger; restarts at MAP0
//   map_addr     in   tile-map byte address, stable until map_step
//   tile_sel     in   1 = unsigned 0x0000 base, 0 = signed 0x1000 base
//   fine_y       in   row within tile
//   stall        in   sprite fetch active; holds X0 states and PUSH
//   bus          if   VRAM read port + FIFO load port (master)
//   map_step     out  one-cycle pulse, coincident with push
//   busy         out  state != IDLE
//   tile_count   out  pushes since fetch_start, saturating
//                     (only with BG_FETCH_TILE_CNT_EN defined)
//
// Configuration macro: BG_FETCH_TILE_CNT_EN adds tile_count / CNT_W.
module bg_tile_fetcher #(
  parameter int VRAM_AW = ppu_pkg::VRAM_AW
`ifdef BG_FETCH_TILE_CNT_EN
  , parameter int CNT_W = 6
`endif
) (
  input  logic               clk2,
  input  logic               reset_video2,
  input  logic               fetch_start,
  input  logic [VRAM_AW-1:0] map_addr,
  input  logic               tile_sel,
  input  logic [2:0]         fine_y,
  input  logic               stall,
  bg_tile_fetcher_if.master  bus,
  output logic               map_step,
  output logic               busy
`ifdef BG_FETCH_TILE_CNT_EN
  , output logic [CNT_W-1:0] tile_count
`endif
);
  import ppu_pkg::*;

  fetch_state_e state;
  fetch_state_e state_n;

  logic [7:0]  idx_q;      // tile index read in MAP1
  logic [7:0]  lo_q;       // low plane staged until the high plane lands
  logic        hi_sel;
  logic [12:0] tile_addr;
  logic        push_ok;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk2 or posedge reset_video2) begin
    if (reset_video2) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ------------------------------------------------------------------
  // Next state and VRAM/FIFO strobes
  // ------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_n     = state;
    bus.vram_rd = 1'b0;
    push_ok     = 1'b0;

    unique case (state)
      IDLE: state_n = IDLE;

      // Address phases: held while a sprite fetch owns VRAM.
      MAP0, LO0, HI0: begin
        bus.vram_rd = !stall;
        if (!stall) begin
          state_n = fetch_state_e'(state + 3'd1);
        end
      end

      // Data phases: the access is already committed, stall is ignored.
      MAP1, LO1, HI1: begin
        bus.vram_rd = 1'b1;
        state_n     = fetch_state_e'(state + 3'd1);
      end

      PUSH: begin
        if (bus.fifo_empty && !stall) begin
          push_ok = 1'b1;
          state_n = MAP0;
        end
      end

      default: state_n = IDLE;
    endcase

    // A (re)start overrides everything, including a ready push.
    if (fetch_start) begin
      state_n = MAP0;
      push_ok = 1'b0;
    end
  end

  assign bus.push = push_ok;
  assign map_step = push_ok;
  assign busy     = (state != IDLE);

  // ------------------------------------------------------------------
  // VRAM address
  // ------------------------------------------------------------------
  assign hi_sel = (state == HI0) || (state == HI1);

  bg_tile_addr u_tile_addr (
    .sel    (tile_sel),
    .idx    (idx_q),
    .fine_y (fine_y),
    .hi     (hi_sel),
    .addr   (tile_addr)
  );

  always_comb begin
    bus.vram_addr = '0;
    unique case (state)
      MAP0, MAP1:        bus.vram_addr = map_addr;
      LO0, LO1, HI0, HI1: bus.vram_addr = tile_addr;
      default:           bus.vram_addr = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Data capture on the edge leaving each X1 state. A concurrent
  // fetch_start discards the in-flight byte. The low plane is staged so
  // pix_lo and pix_hi change together and stay stable for a whole tile.
  // ------------------------------------------------------------------
  always_ff @(posedge clk2 or posedge reset_video2) begin
    if (reset_video2) begin
      idx_q      <= 8'h00;
      lo_q       <= 8'h00;
      bus.pix_lo <= 8'h00;
      bus.pix_hi <= 8'h00;
    end else if (!fetch_start) begin
      unique case (state)
        MAP1: idx_q <= bus.vram_data;
        LO1:  lo_q  <= bus.vram_data;
        HI1: begin
          bus.pix_lo <= lo_q;
          bus.pix_hi <= bus.vram_data;
        end
        default: ;
      endcase
    end
  end

`ifdef BG_FETCH_TILE_CNT_EN
  // Tiles pushed since the last fetch_start, saturating at all-ones.
  always_ff @(posedge clk2 or posedge reset_video2) begin
    if (reset_video2) begin
      tile_count <= '0;
    end else if (fetch_start) begin
      tile_count <= '0;
    end else if (push_ok && (tile_count != {CNT_W{1'b1}})) begin
      tile_count <= tile_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// tb_bg_tile_fetcher: self-checking bench for bg_tile_fetcher.
// A registered VRAM model answers reads; a reference model computes the
// expected address sequence, pixel bytes and tile counts from the
// tile-map/tile-data layout using plain arithmetic.
// Build with BG_FETCH_TILE_CNT_EN defined to also exercise tile_count.
module tb_bg_tile_fetcher;

  logic        clk2;
  logic        reset_video2;
  logic        fetch_start;
  logic [12:0] map_addr;
  logic        tile_sel;
  logic [2:0]  fine_y;
  logic        stall;
  logic        map_step;
  logic        busy;
`ifdef BG_FETCH_TILE_CNT_EN
  logic [5:0]  tile_count;
`endif

  bg_tile_fetcher_if #(.AW(13)) bus ();

  bg_tile_fetcher dut (
    .clk2         (clk2),
    .reset_video2 (reset_video2),
    .fetch_start  (fetch_start),
    .map_addr     (map_addr),
    .tile_sel     (tile_sel),
    .fine_y       (fine_y),
    .stall        (stall),
    .bus          (bus),
    .map_step     (map_step),
    .busy         (busy)
`ifdef BG_FETCH_TILE_CNT_EN
    , .tile_count (tile_count)
`endif
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // VRAM: data for the address presented in a cycle with vram_rd high
  // appears in the following cycle; otherwise the bus carries junk.
  logic [7:0] mem [0:8191];
  always @(posedge clk2) begin
    if (bus.vram_rd) bus.vram_data <= mem[bus.vram_addr];
    else             bus.vram_data <= 8'($urandom);
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_lo = 8'h00;
  logic [7:0] exp_hi = 8'h00;
  int         tcount = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge clk2);
    #1;
  endtask

  // Tile-data address from the map layout: 16 bytes per tile, 2 per row.
  function automatic logic [12:0] ref_addr(input logic sel, input logic [7:0] idx,
                                           input logic [2:0] fy, input logic hi);
    int sidx;
    int base;
    sidx = (idx >= 8'd128) ? int'(idx) - 256 : int'(idx);
    base = sel ? int'(idx) * 16 : 4096 + sidx * 16;
    return 13'(base + int'(fy) * 2 + int'(hi));
  endfunction

  // One cycle of an in-progress access: rd_exp < 0 skips the strobe check.
  task automatic see(input string tag, input int rd_exp, input logic [12:0] a_exp);
    @(negedge clk2);
    if (rd_exp >= 0) chk({tag, ".rd"}, 32'(bus.vram_rd), 32'(rd_exp));
    chk({tag, ".addr"}, 32'(bus.vram_addr), 32'(a_exp));
    chk({tag, ".push"}, 32'(bus.push), 32'd0);
    chk({tag, ".map_step"}, 32'(map_step), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".pix_lo"}, 32'(bus.pix_lo), 32'(exp_lo));
    chk({tag, ".pix_hi"}, 32'(bus.pix_hi), 32'(exp_hi));
  endtask

  // Runs one tile starting in a MAP0 cycle; returns in the next MAP0 cycle.
  // abort: 0 none, 1 fetch_start in HI1, 2 fetch_start in a ready PUSH.
  task automatic fetch_tile(input logic [12:0] maddr, input logic sel, input logic [2:0] fy,
                            input int lo0_stall, input bit hi1_stall, input int block,
                            input int abort);
    logic [7:0]  idx;
    logic [12:0] lo_a;
    logic [12:0] hi_a;
    map_addr    = maddr;
    tile_sel    = sel;
    fine_y      = fy;
    stall       = 1'b0;
    fifo_drive(1'b1);
    fetch_start = 1'b0;
    idx  = mem[maddr];
    lo_a = ref_addr(sel, idx, fy, 1'b0);
    hi_a = ref_addr(sel, idx, fy, 1'b1);

    see("map0", 1, maddr); next();
    see("map1", 1, maddr); next();
    for (int k = 0; k < lo0_stall; k++) begin
      stall = 1'b1;
      see("lo0_stalled", 0, lo_a); next();
    end
    stall = 1'b0;
    see("lo0", 1, lo_a); next();
    see("lo1", 1, lo_a); next();
    see("hi0", 1, hi_a); next();
    stall = hi1_stall;
    if (abort == 1) fetch_start = 1'b1;
    see("hi1", hi1_stall ? -1 : 1, hi_a); next();
    stall = 1'b0;
    if (abort == 1) begin
      fetch_start = 1'b0;
      tcount = 0;
      return;
    end
    exp_lo = mem[lo_a];
    exp_hi = mem[hi_a];

    for (int k = 0; k < block; k++) begin
      fifo_drive(1'b0);
      @(negedge clk2);
      chk("push_wait.push", 32'(bus.push), 32'd0);
      chk("push_wait.map_step", 32'(map_step), 32'd0);
      chk("push_wait.rd", 32'(bus.vram_rd), 32'd0);
      chk("push_wait.busy", 32'(busy), 32'd1);
      next();
    end
    fifo_drive(1'b1);
    if (abort == 2) fetch_start = 1'b1;
    @(negedge clk2);
    chk("push.push", 32'(bus.push), (abort == 2) ? 32'd0 : 32'd1);
    chk("push.map_step", 32'(map_step), (abort == 2) ? 32'd0 : 32'd1);
    chk("push.rd", 32'(bus.vram_rd), 32'd0);
    chk("push.pix_lo", 32'(bus.pix_lo), 32'(exp_lo));
    chk("push.pix_hi", 32'(bus.pix_hi), 32'(exp_hi));
`ifdef BG_FETCH_TILE_CNT_EN
    chk("push.tile_count", 32'(tile_count), 32'(tcount));
`endif
    next();
    fetch_start = 1'b0;
    if (abort == 2)     tcount = 0;
    else if (tcount < 63) tcount++;
  endtask

  task automatic fifo_drive(input logic v);
    bus.fifo_empty = v;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".rd"}, 32'(bus.vram_rd), 32'd0);
    chk({tag, ".addr"}, 32'(bus.vram_addr), 32'd0);
    chk({tag, ".push"}, 32'(bus.push), 32'd0);
    chk({tag, ".map_step"}, 32'(map_step), 32'd0);
    chk({tag, ".pix_lo"}, 32'(bus.pix_lo), 32'd0);
    chk({tag, ".pix_hi"}, 32'(bus.pix_hi), 32'd0);
`ifdef BG_FETCH_TILE_CNT_EN
    chk({tag, ".tile_count"}, 32'(tile_count), 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

    // Reset held while inputs toggle: outputs must stay at reset values.
    reset_video2 = 1'b1;
    fetch_start  = 1'b0;
    map_addr     = 13'h1800;
    tile_sel     = 1'b1;
    fine_y       = 3'd0;
    stall        = 1'b0;
    fifo_drive(1'b1);
    for (int i = 0; i < 4; i++) begin
      next();
      fetch_start = 1'($urandom);
      stall       = 1'($urandom);
      fifo_drive(1'($urandom));
      @(negedge clk2);
      check_reset_values("in_reset");
    end
    fetch_start = 1'b0;
    stall       = 1'b0;
    fifo_drive(1'b1);
    next();
    reset_video2 = 1'b0;
    next();
    @(negedge clk2);
    chk("idle.busy", 32'(busy), 32'd0);

    // Start: fetch_start in cycle N, MAP0 (vram_rd high) in N+1.
    mem[13'h1800] = 8'h05;
    mem[13'h0056] = 8'h3C;
    mem[13'h0057] = 8'hA5;
    next();
    fetch_start = 1'b1;
    @(negedge clk2);
    chk("start.rd", 32'(bus.vram_rd), 32'd0);
    chk("start.push", 32'(bus.push), 32'd0);
    next();
    tcount = 0;
    fetch_tile(13'h1800, 1'b1, 3'd3, 0, 1'b0, 0, 0);
    chk("directed.pix_lo", 32'(exp_lo), 32'h3C);
    chk("directed.pix_hi", 32'(exp_hi), 32'hA5);

    // Signed addressing boundaries, back to back.
    mem[13'h1900] = 8'h80;
    mem[13'h1901] = 8'h7F;
    mem[13'h1902] = 8'h00;
    chk("signed.0x80", 32'(ref_addr(1'b0, 8'h80, 3'd2, 1'b0)), 32'h0804);
    fetch_tile(13'h1900, 1'b0, 3'd2, 0, 1'b0, 0, 0);
    fetch_tile(13'h1901, 1'b0, 3'd5, 0, 1'b0, 0, 0);
    fetch_tile(13'h1902, 1'b0, 3'd7, 0, 1'b0, 0, 0);

    // FIFO full for 5 cycles in PUSH, then a single push.
    fetch_tile(13'h1A10, 1'b1, 3'd1, 0, 1'b0, 5, 0);
    // Stall 3 cycles in LO0 and once in HI1.
    fetch_tile(13'h1A11, 1'b0, 3'd4, 3, 1'b1, 0, 0);

    // Restart during HI1 and during a ready PUSH: no push, MAP0 next.
    fetch_tile(13'h1A12, 1'b1, 3'd6, 0, 1'b0, 0, 1);
    fetch_tile(13'h1A13, 1'b0, 3'd0, 0, 1'b0, 0, 2);
    fetch_tile(13'h1A14, 1'b1, 3'd3, 0, 1'b0, 0, 0);

    // Randomized run, long enough to saturate the tile counter.
    for (int t = 0; t < 70; t++) begin
      fetch_tile(13'h1800 + 13'($urandom_range(0, 2047)), 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                 1'($urandom), int'($urandom_range(0, 2)), 0);
    end
`ifdef BG_FETCH_TILE_CNT_EN
    @(negedge clk2);
    chk("tile_count.sat", 32'(tile_count), 32'd63);
`endif

    // Reset in the middle of a fetch: immediate return to reset values.
    map_addr = 13'h1B00;
    see("pre_reset.map0", 1, 13'h1B00); next();
    see("pre_reset.map1", 1, 13'h1B00); next();
    #2;
    reset_video2 = 1'b1;
    #1;
    exp_lo = 8'h00;
    exp_hi = 8'h00;
    tcount = 0;
    check_reset_values("mid_reset");
    next();
    reset_video2 = 1'b0;
    next();
    @(negedge clk2);
    chk("post_reset.busy", 32'(busy), 32'd0);

    // Restart after reset works normally.
    next();
    fetch_start = 1'b1;
    next();
    fetch_tile(13'h1C00, 1'b0, 3'd5, 0, 1'b0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
